// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter granting four requesters access to one shared register.
// Each transaction takes two cycles: IDLE picks a winner at a clock edge and
// the following GRANT cycle drives the register-side controls for exactly one
// cycle. All outputs are registered.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   clr        asynchronous active-high reset
//   req        [3:0]      per-requester access request
//   req_clear  [3:0]      per-requester op: 1 = clear register, 0 = write it
//   req_data   [4*DW-1:0] packed write data, requester i at [i*DW +: DW]
//   hold       freezes new grants while high (does not stretch GRANT)
//   gnt        [3:0]      one-hot grant pulse to the winner
//   reg_data   [DW-1:0]   data to the shared register
//   reg_we     write enable to the shared register
//   reg_clr    synchronous clear to the shared register
//   owner      [1:0]      index of the most recently granted requester
//   busy       high while the FSM is in GRANT
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [3:0]      req,
  input  logic [3:0]      req_clear,
  input  logic [4*DW-1:0] req_data,
  input  logic            hold,
  output logic [3:0]      gnt,
  output logic [DW-1:0]   reg_data,
  output logic            reg_we,
  output logic            reg_clr,
  output logic [1:0]      owner,
  output logic            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [3:0]    gnt_nxt;
  logic [DW-1:0] reg_data_nxt;
  logic          reg_we_nxt;
  logic          reg_clr_nxt;
  logic [1:0]    owner_nxt;
  logic          busy_nxt;

  // Round-robin search: start one past the last winner and walk upward with
  // wrap; the 2-bit addition provides the modulo-4 wrap for free.
  logic [1:0] win;
  logic       found;
  logic [1:0] cand;

  always_comb begin
    win   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gnt_nxt      = '0;
    reg_data_nxt = reg_data;
    reg_we_nxt   = 1'b0;
    reg_clr_nxt  = 1'b0;
    owner_nxt    = owner;
    busy_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (!hold && found) begin
          state_nxt      = GRANT;
          ptr_nxt        = win;
          gnt_nxt        = 4'b0001 << win;
          owner_nxt      = win;
          busy_nxt       = 1'b1;
          if (req_clear[win]) begin
            reg_clr_nxt  = 1'b1;
            reg_data_nxt = '0;
          end else begin
            reg_we_nxt   = 1'b1;
            reg_data_nxt = req_data[int'(win)*DW +: DW];
          end
        end
      end
      GRANT: begin
        // Unconditional return: req and hold are ignored for one cycle, so
        // the transaction in flight is never altered or stretched.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. ptr resets to 3 so the first search after
  // reset starts at requester 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      gnt      <= '0;
      reg_data <= '0;
      reg_we   <= 1'b0;
      reg_clr  <= 1'b0;
      owner    <= 2'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      reg_data <= reg_data_nxt;
      reg_we   <= reg_we_nxt;
      reg_clr  <= reg_clr_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter: DW, default 32, data width of the shared register and of each requester's data port.
REQ-002 Port: clk  input  1  clock; all state changes on the positive edge.
REQ-003 Port: clr  input  1  reset; asynchronous, active-high.
REQ-004 Port: req  input  4  per-requester access request; bit i belongs to requester i.
REQ-005 Port: req_clear  input  4  per-requester op select: 1 = clear the register, 0 = write it.
REQ-006 Port: req_data  input  4*DW  packed write data; requester i uses bits [i*DW+DW-1 : i*DW].
REQ-007 Port: hold  input  1  freezes arbitration while high.
REQ-008 Port: gnt  output  4  one-hot grant pulse to the winning requester.
REQ-009 Port: reg_data  output  DW  data to the shared register's data input.
REQ-010 Port: reg_we  output  1  write-enable to the shared register.
REQ-011 Port: reg_clr  output  1  synchronous clear to the shared register.
REQ-012 Port: owner  output  2  index of the most recently granted requester.
REQ-013 Port: busy  output  1  high while the FSM is in GRANT.

Function
REQ-014 Two-state FSM, IDLE and GRANT; every output is a register.
REQ-015 IDLE, hold=0, req!=0 at a clock edge: latch the winner and go to GRANT; at the same edge set gnt, owner and the register-side outputs for that winner.
REQ-016 IDLE with hold=1 or req=0: stay in IDLE; gnt, reg_we and reg_clr are 0.
REQ-017 GRANT always returns to IDLE on the next edge, whatever req or hold are doing; gnt, reg_we and reg_clr drop to 0 on that edge.
REQ-018 Each transaction takes exactly 2 cycles, so the maximum rate is one register update every 2 cycles.
REQ-019 gnt, reg_we and reg_clr are high for exactly one cycle per transaction, in the GRANT cycle.
REQ-020 Requester i holds req[i], req_clear[i] and its data slice stable until it sees gnt[i]=1. It deasserts req[i] in the gnt cycle, or keeps it high to queue another request.
REQ-021 Round-robin arbitration: search starts at (ptr+1) mod 4 and goes upward with wrap, and the first asserted req wins.
REQ-022 ptr is set to the winner index on every grant.
REQ-023 In GRANT, reg_clr = req_clear of the winner and reg_we = NOT req_clear of the winner; both are never high together.
REQ-024 reg_data = the winner's data slice sampled at the grant edge on a write; on a clear it is 0.
REQ-025 reg_data holds its value outside GRANT.
REQ-026 owner updates only on a grant and otherwise holds.
REQ-027 Requests that change during GRANT do not affect the current transaction.
REQ-028 hold sampled high in GRANT does not extend the GRANT cycle; hold only blocks new grants from IDLE.
REQ-029 req bits with no grant are never dropped or flagged, because the arbiter holds no queue; requesters keep asserting.
REQ-030 Starvation bound: a continuously asserted req[i] is granted within 4 transactions (8 cycles while hold=0).

Reset
REQ-031 While clr=1, asynchronously: state=IDLE, ptr=3, gnt=0, reg_we=0, reg_clr=0, reg_data=0, owner=0, busy=0.
REQ-032 clr asserted during GRANT aborts the transaction immediately and drops reg_we/reg_clr before the next edge; no retry.
REQ-033 First edge with clr=0: normal IDLE evaluation, with requester 0 at highest priority.

Verification
REQ-034 Reset then req=4'b0001, req_clear=0, data0=32'hDEADBEEF -> next edge: gnt=0001, reg_we=1, reg_data=DEADBEEF, owner=0, busy=1; the edge after: gnt=0, reg_we=0, busy=0.
REQ-035 req=4'b1111 held continuously, hold=0 -> grants 0,1,2,3,0 on cycles 1,3,5,7,9; gnt is never high in consecutive cycles.
REQ-036 req=4'b0100 with req_clear=4'b0100, data2=32'h12345678 -> reg_clr=1, reg_we=0, reg_data=0, owner=2 for one cycle.
REQ-037 hold=1 with req=4'b0010 for 5 cycles -> no gnt and busy=0; hold drops -> gnt=0010 on the next edge.
REQ-038 clr pulsed mid-cycle during GRANT (owner=3) -> reg_we, gnt and owner become 0 before the next edge. Then with req=4'b1001, requester 0 wins first.
REQ-039 Starvation check, constant req=4'b1011 for 16 cycles -> each of requesters 0, 1 and 3 is granted at least twice, and requester 2 is never granted.
